// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog escalation block.
// Holds the FSM state encoding and the majority helper used by the voter.
package wdt_pkg;

    localparam int N_WDT = 3;
    localparam int EVT_W = 8;

    typedef logic [1:0] wdt_state_t;

    // The encoding is visible on state_o, so it must not be reordered.
    localparam wdt_state_t ST_IDLE    = 2'b00;
    localparam wdt_state_t ST_WARN    = 2'b01;
    localparam wdt_state_t ST_RESET   = 2'b10;
    localparam wdt_state_t ST_HOLDOFF = 2'b11;

    function automatic logic majority3(input logic [N_WDT-1:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Registered 2-of-3 majority of the watchdog expiry levels, with a disagree
// flag and a one-cycle vote history that exports a rising-edge strobe.
module tmr_vote
    import wdt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_WDT-1:0] expired_in,
    output logic             voted,
    output logic             disagree,
    output logic             rise
);

    logic voted_q;
    logic voted_d;
    logic disagree_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted_q    <= 1'b0;
            voted_d    <= 1'b0;
            disagree_q <= 1'b0;
        end else begin
            voted_q    <= majority3(expired_in);
            voted_d    <= voted_q;
            disagree_q <= !((&expired_in) | (~|expired_in));
        end
    end

    // The history updates in every FSM state, so an edge seen during
    // HOLDOFF is consumed rather than deferred until IDLE.
    assign rise     = voted_q & ~voted_d;
    assign voted    = voted_q;
    assign disagree = disagree_q;

endmodule

// File: rtl/wdt_escalation.sv
// Escalation FSM on the voted watchdog expiry: interrupt, grace period for
// software ack, system reset pulse, then a holdoff window ignoring triggers.
module wdt_escalation
    import wdt_pkg::*;
#(
    parameter int GRACE_CYCLES     = 1000,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES   = 64,
    parameter int CNT_W            = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_WDT-1:0]    expired_in,
    input  logic                ack,
    output logic                irq,
    output logic                sys_rst_req,
    output logic                disagree,
    output logic [1:0]          state_o,
    output logic [EVT_W-1:0]    event_count
);

    localparam logic [CNT_W-1:0] GRACE_LD   = CNT_W'(GRACE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_MAX    = '1;
    localparam logic [EVT_W-1:0] EVT_ONE    = EVT_W'(1);

    logic             rise;
    logic             voted_unused;
    wdt_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [EVT_W-1:0] evt_q,   evt_d;
    logic             cnt_zero;

    tmr_vote u_vote (
        .clk        (clk),
        .rst_n      (rst_n),
        .expired_in (expired_in),
        .voted      (voted_unused),
        .disagree   (disagree),
        .rise       (rise)
    );

    assign cnt_zero = (cnt_q == '0);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = evt_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_WARN;
                    cnt_d   = GRACE_LD;
                    if (evt_q != EVT_MAX) begin
                        evt_d = evt_q + EVT_ONE;
                    end
                end
            end
            ST_WARN: begin
                // Acknowledge takes priority over grace expiry.
                if (ack) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_RESET;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESET: begin
                if (cnt_zero) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLDOFF_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    // Moore decode from the state register: the reset request drops as soon
    // as rst_n clears the state, with no input-to-output path.
    assign irq         = (state_q == ST_WARN) || (state_q == ST_RESET);
    assign sys_rst_req = (state_q == ST_RESET);
    assign state_o     = state_q;
    assign event_count = evt_q;

endmodule

// File: tb/tb_wdt_escalation.sv
// Scoreboard bench for wdt_escalation: a timeline model predicts outputs per
// cycle, a monitor compares them against the DUT after each clock edge.
module tb_wdt_escalation;

    localparam int G = 4;
    localparam int P = 3;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] expired_in = 3'b000;
    logic       ack = 1'b0;
    logic       irq;
    logic       sys_rst_req;
    logic       disagree;
    logic [1:0] state_o;
    logic [7:0] event_count;

    int checks = 0;
    int errors = 0;

    wdt_escalation #(
        .GRACE_CYCLES     (G),
        .RST_PULSE_CYCLES (P),
        .HOLDOFF_CYCLES   (H),
        .CNT_W            (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .expired_in  (expired_in),
        .ack         (ack),
        .irq         (irq),
        .sys_rst_req (sys_rst_req),
        .disagree    (disagree),
        .state_o     (state_o),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus absolute cycle index at which it ends.
    typedef enum {M_IDLE, M_WARN, M_RST, M_HOLD} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_end  = 0;
    int    cyc    = 0;
    int    m_evt  = 0;
    bit    m_vq   = 0;
    bit    m_vd   = 0;
    bit    m_dis  = 0;

    logic [12:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] model_out();
        logic [1:0] st;
        case (m_mode)
            M_IDLE:  st = 2'b00;
            M_WARN:  st = 2'b01;
            M_RST:   st = 2'b10;
            default: st = 2'b11;
        endcase
        return {(m_mode == M_WARN || m_mode == M_RST), (m_mode == M_RST), m_dis, st, 8'(m_evt)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_end = 0; m_evt = 0; m_vq = 0; m_vd = 0; m_dis = 0;
    endtask

    task automatic model_edge(input logic [2:0] in_v, input logic ack_v);
        bit rise_v;
        rise_v = m_vq && !m_vd;
        case (m_mode)
            M_IDLE: if (rise_v) begin
                m_mode = M_WARN;
                m_end  = cyc + G;
                if (m_evt < 255) m_evt++;
            end
            M_WARN: begin
                if (ack_v) m_mode = M_IDLE;
                else if (cyc == m_end) begin m_mode = M_RST; m_end = cyc + P; end
            end
            M_RST: if (cyc == m_end) begin m_mode = M_HOLD; m_end = cyc + H; end
            default: if (cyc == m_end) m_mode = M_IDLE;
        endcase
        m_vd  = m_vq;
        m_vq  = ($countones(in_v) >= 2);
        m_dis = (in_v != 3'b000) && (in_v != 3'b111);
        cyc++;
    endtask

    task automatic step(input logic [2:0] in_v, input logic ack_v);
        @(negedge clk);
        expired_in = in_v;
        ack        = ack_v;
        model_edge(in_v, ack_v);
        exp_q.push_back(model_out());
    endtask

    task automatic run(input int n, input logic [2:0] in_v);
        for (int i = 0; i < n; i++) step(in_v, 1'b0);
    endtask

    task automatic until_mode(input mode_t m, input logic [2:0] in_v);
        int budget;
        budget = 50;
        while (m_mode != m && budget > 0) begin
            step(in_v, 1'b0);
            budget--;
        end
        check("mode_reached", 32'(m_mode), 32'(m));
    endtask

    // Monitor: one expected record per driven cycle, compared after the edge.
    initial begin
        logic [12:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", {irq, sys_rst_req, disagree, state_o, event_count}, e);
            end
        end
    end

    initial begin
        #1;
        check("reset_outputs", {irq, sys_rst_req, disagree, state_o, event_count}, 13'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Majority trigger without ack, vote held high into IDLE: no retrigger.
        run(3, 3'b000);
        run(25, 3'b111);
        check("held_vote_no_retrigger", {30'd0, state_o}, 32'd0);
        // Vote falls then rises again in IDLE: new WARN.
        run(3, 3'b000);
        until_mode(M_WARN, 3'b111);
        until_mode(M_IDLE, 3'b111);
        run(3, 3'b000);

        // Acknowledge in the 2nd WARN cycle.
        until_mode(M_WARN, 3'b011);
        step(3'b011, 1'b0);
        step(3'b011, 1'b1);
        run(4, 3'b000);

        // Ack coinciding with grace expiry, with a rise attempt from vote pulse.
        until_mode(M_WARN, 3'b110);
        begin
            int budget;
            budget = 20;
            while (cyc != m_end && budget > 0) begin step(3'b110, 1'b0); budget--; end
        end
        step(3'b110, 1'b1);
        check("ack_at_expiry_idle", {30'd0, 2'(m_mode == M_IDLE)}, 32'd1);
        run(3, 3'b000);

        // Single watchdog fault: disagree only.
        run(20, 3'b100);
        run(3, 3'b000);

        // Vote pulse 1-0-1 during HOLDOFF is ignored.
        until_mode(M_WARN, 3'b111);
        until_mode(M_HOLD, 3'b111);
        step(3'b000, 1'b0);
        step(3'b111, 1'b0);
        run(10, 3'b111);
        run(3, 3'b000);

        // Asynchronous reset during the 2nd sys_rst_req cycle.
        until_mode(M_WARN, 3'b111);
        until_mode(M_RST, 3'b111);
        step(3'b111, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        expired_in = 3'b000;
        #1;
        check("async_reset_outputs", {irq, sys_rst_req, disagree, state_o, event_count}, 13'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_release_state_evt", {22'd0, state_o, event_count}, 32'd0);

        // Randomized stretch: inputs held for random lengths, sparse acks.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] v;
            int len;
            v   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) step(v, 1'($urandom_range(0, 9) == 0));
        end

        // Drive the event counter to saturation using trigger/ack cycles.
        for (int i = 0; i < 270; i++) begin
            run(2, 3'b000);
            until_mode(M_WARN, 3'b111);
            step(3'b111, 1'b1);
        end
        run(2, 3'b000);
        @(negedge clk);
        check("event_count_saturated", {24'd0, event_count}, 32'd255);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
